mul_12_add: RTL

- Inverse of the clock's divide-by-12 hour split: reconstructs a 6-bit value as numerator = quotient*12 + remainder.
- Used when the user sets time or alarm in 12-hour form (quotient = AM/PM/half-day index, remainder = hour-in-half), producing the 0..63 linear hour/count value the counters store.
- Multi-cycle shift-add datapath with valid/ready handshakes on both sides; range checking on inputs and result.

---
 rtl/mul12_pkg.sv | 28 ++
 rtl/mul12_datapath.sv | 97 +++++++++
 rtl/mul_12_add.sv | 84 ++++++++
 3 files changed

// File: rtl/mul12_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul12_pkg
//  Description : Shared widths, range limits and FSM encoding for the
//                multiply-by-12-and-add block (12-hour to linear hour).
//  Revision    : 1.0  initial release
// ============================================================================
package mul12_pkg;

  localparam int QW      = 3;       // quotient width
  localparam int RW      = 4;       // remainder width
  localparam int NW      = 6;       // result width
  localparam int AW      = NW + 1;  // accumulator width, top bit is overflow

  localparam int DIVISOR = 12;
  localparam int MAX_REM = 11;
  localparam int NMAX    = 63;

  // Shift-add sequence: q*12 is built as (q<<3) + (q<<2)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD8 = 2'd1,
    ST_ADD4 = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mul12_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : mul12_datapath
//  Description : Operand latches, 7-bit shift-add accumulator and result /
//                error register for mul_12_add. Optional saturation on
//                overflow is enabled by defining MUL12_SAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module mul12_datapath
  import mul12_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  state_t        state,
  input  logic          load,
  input  logic          release_out,
  input  logic [QW-1:0] quotient,
  input  logic [RW-1:0] remainder,
  output logic [NW-1:0] numerator,
  output logic          err_rem,
  output logic          err_ovf
);

  localparam logic [RW-1:0] C_MAX_REM = RW'(MAX_REM);

  logic [QW-1:0] r_q;
  logic [RW-1:0] r_rem;
  logic [AW-1:0] r_acc;

  logic [AW-1:0] w_addend;
  logic [AW-1:0] w_acc_sum;
  logic          w_err_rem;
  logic          w_err_ovf;
  logic [NW-1:0] w_num;

  // Pick the shifted quotient term that belongs to the current step
  always_comb begin
    w_addend = '0;
    case (state)
      ST_ADD8: w_addend = {1'b0, r_q, 3'b000};
      ST_ADD4: w_addend = {2'b00, r_q, 2'b00};
      default: w_addend = '0;
    endcase
  end

  assign w_acc_sum = r_acc + w_addend;
  assign w_err_rem = (r_rem > C_MAX_REM);
  assign w_err_ovf = w_acc_sum[AW-1];

  // Final value as it will be presented, judged on the completed sum
  always_comb begin
    w_num = w_acc_sum[NW-1:0];
`ifdef MUL12_SAT_EN
    if (w_err_rem)
      w_num = '0;
    else if (w_err_ovf)
      w_num = NW'(NMAX);
`else
    if (w_err_rem || w_err_ovf)
      w_num = '0;
`endif
  end

  // Latch operands on accept, then accumulate one shifted term per step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_rem <= '0;
      r_acc <= '0;
    end else if (load) begin
      r_q   <= quotient;
      r_rem <= remainder;
      r_acc <= AW'(remainder);
    end else if (state == ST_ADD8 || state == ST_ADD4) begin
      r_acc <= w_acc_sum;
    end
  end

  // Capture result and flags on the last add; clear them once consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      numerator <= '0;
      err_rem   <= 1'b0;
      err_ovf   <= 1'b0;
    end else if (state == ST_ADD4) begin
      numerator <= w_num;
      err_rem   <= w_err_rem;
      err_ovf   <= w_err_ovf;
    end else if (release_out) begin
      numerator <= '0;
      err_rem   <= 1'b0;
      err_ovf   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_12_add.sv
`default_nettype none
// ============================================================================
//  Module      : mul_12_add
//  Description : Rebuilds a 6-bit linear hour value as quotient*12+remainder
//                over four cycles with valid/ready on both sides. Remainder
//                range and result overflow are flagged with the result.
//                Define MUL12_SAT_EN to saturate overflowing results to 63.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_12_add
  import mul12_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] quotient,
  input  logic [RW-1:0] remainder,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] numerator,
  output logic          err_rem,
  output logic          err_ovf
);

  state_t r_state;
  logic   w_accept;
  logic   w_release;

  assign w_accept  = (r_state == ST_IDLE) && in_valid && in_ready;
  assign w_release = out_valid && out_ready;

  // Sequencer with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            r_state  <= ST_ADD8;
            in_ready <= 1'b0;
          end
        end
        ST_ADD8: begin
          r_state <= ST_ADD4;
        end
        ST_ADD4: begin
          r_state   <= ST_DONE;
          out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  mul12_datapath u_datapath (
    .clk         (clk),
    .rst         (rst),
    .state       (r_state),
    .load        (w_accept),
    .release_out (w_release),
    .quotient    (quotient),
    .remainder   (remainder),
    .numerator   (numerator),
    .err_rem     (err_rem),
    .err_ovf     (err_ovf)
  );

endmodule
`default_nettype wire
